// File: rtl/ysyx_23060201_gpr_wb_sched.sv
// rtl/ysyx_23060201_gpr_wb_sched.sv - GPR writeback arbiter, commit stage and destination scoreboard
// Optional commit-stage read bypass: define YSYX_23060201_GPR_WB_BYPASS_EN.
module ysyx_23060201_gpr_wb_sched #(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iss_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] iss_rd,
  output logic                      iss_ready,
  input  logic                      exu_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0]     exu_data,
  output logic                      exu_ready,
  input  logic                      lsu_valid,
  input  logic [GPR_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]     lsu_data,
  output logic                      lsu_ready,
  input  logic [1:0]                rd_ren,
  input  logic [GPR_ADDR_WIDTH-1:0] rd_raddr1,
  input  logic [GPR_ADDR_WIDTH-1:0] rd_raddr2,
  output logic                      hazard,
`ifdef YSYX_23060201_GPR_WB_BYPASS_EN
  output logic [1:0]                byp_hit,
  output logic [DATA_WIDTH-1:0]     byp_data1,
  output logic [DATA_WIDTH-1:0]     byp_data2,
`endif
  output logic                      gpr_wen,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0]     gpr_wdata
);

  localparam int NREG = 1 << GPR_ADDR_WIDTH;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  src_e                      last_grant;
  logic [NREG-1:0]           busy_q;
  logic [NREG-1:0]           busy_d;
  logic                      grant_exu;
  logic                      grant_lsu;
  logic                      accept;
  logic [GPR_ADDR_WIDTH-1:0] acc_rd;
  logic [DATA_WIDTH-1:0]     acc_data;
  logic                      acc_write;
  logic                      iss_fire;
  logic                      haz1;
  logic                      haz2;

  // Round-robin: on a tie the requester that did not win last time goes first.
  always_comb begin
    grant_exu = 1'b0;
    grant_lsu = 1'b0;
    if (exu_valid && lsu_valid) begin
      grant_exu = (last_grant == SRC_LSU);
      grant_lsu = (last_grant == SRC_EXU);
    end else begin
      grant_exu = exu_valid;
      grant_lsu = lsu_valid;
    end
  end

  assign exu_ready = grant_exu;
  assign lsu_ready = grant_lsu;
  assign accept    = grant_exu | grant_lsu;
  assign acc_rd    = grant_lsu ? lsu_rd   : exu_rd;
  assign acc_data  = grant_lsu ? lsu_data : exu_data;
  assign acc_write = accept & (acc_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_LSU;
    end else if (accept) begin
      last_grant <= grant_lsu ? SRC_LSU : SRC_EXU;
    end
  end

  // Commit stage; x0 writes are accepted but never reach the GPR file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
    end else begin
      gpr_wen <= acc_write;
      if (acc_write) begin
        gpr_waddr <= acc_rd;
        gpr_wdata <= acc_data;
      end
    end
  end

  assign iss_ready = (iss_rd == '0) | ~busy_q[iss_rd];
  assign iss_fire  = iss_valid & iss_ready;

  // Clear first, then set, so an issue on the committing register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (gpr_wen) begin
      busy_d[gpr_waddr] = 1'b0;
    end
    if (iss_fire && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

`ifdef YSYX_23060201_GPR_WB_BYPASS_EN
  always_comb begin
    byp_hit[0] = rd_ren[0] & gpr_wen & (gpr_waddr == rd_raddr1) & (gpr_waddr != '0);
    byp_hit[1] = rd_ren[1] & gpr_wen & (gpr_waddr == rd_raddr2) & (gpr_waddr != '0);
  end
  assign byp_data1 = gpr_wdata;
  assign byp_data2 = gpr_wdata;
  assign haz1 = rd_ren[0] & busy_q[rd_raddr1] & ~byp_hit[0];
  assign haz2 = rd_ren[1] & busy_q[rd_raddr2] & ~byp_hit[1];
`else
  assign haz1 = rd_ren[0] & busy_q[rd_raddr1];
  assign haz2 = rd_ren[1] & busy_q[rd_raddr2];
`endif

  assign hazard = haz1 | haz2;

  // A writeback to a register that nothing issued is legal but usually a pipeline bug.
  wb_to_idle_reg: assert property (@(posedge clk) disable iff (!rst_n) gpr_wen |-> busy_q[gpr_waddr]);

endmodule

// File: tb/tb_ysyx_23060201_gpr_wb_sched.sv
// tb/tb_ysyx_23060201_gpr_wb_sched.sv - self-checking bench for ysyx_23060201_gpr_wb_sched
module tb_ysyx_23060201_gpr_wb_sched;

  logic        clk;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        exu_valid;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        exu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic [1:0]  rd_ren;
  logic [4:0]  rd_raddr1;
  logic [4:0]  rd_raddr2;
  logic        hazard;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
`ifdef YSYX_23060201_GPR_WB_BYPASS_EN
  logic [1:0]  byp_hit;
  logic [31:0] byp_data1;
  logic [31:0] byp_data2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: which registers are awaiting writeback, the pending commit, and who won last.
  bit          mbusy [32];
  bit          mwen;
  logic [4:0]  mwaddr;
  logic [31:0] mwdata;
  bit          mlast_lsu;

  ysyx_23060201_gpr_wb_sched #(.GPR_ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rd_ren(rd_ren), .rd_raddr1(rd_raddr1), .rd_raddr2(rd_raddr2), .hazard(hazard),
`ifdef YSYX_23060201_GPR_WB_BYPASS_EN
    .byp_hit(byp_hit), .byp_data1(byp_data1), .byp_data2(byp_data2),
`endif
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    mwen      = 1'b0;
    mwaddr    = '0;
    mwdata    = '0;
    mlast_lsu = 1'b1;
  endtask

  task automatic idle_inputs();
    iss_valid = 0; iss_rd = 0;
    exu_valid = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    rd_ren = 0; rd_raddr1 = 0; rd_raddr2 = 0;
  endtask

  // Called after a negedge with inputs set: checks combinational outputs, steps one edge, checks commit.
  task automatic cycle();
    bit ge, gl, e_iss, e_haz, acc, b1, b2;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    #1;
    if (exu_valid && lsu_valid) begin
      ge = mlast_lsu;
      gl = !mlast_lsu;
    end else begin
      ge = exu_valid;
      gl = lsu_valid;
    end
    e_iss = (iss_rd == 0) || !mbusy[iss_rd];
    b1 = rd_ren[0] && mwen && (mwaddr == rd_raddr1) && (mwaddr != 0);
    b2 = rd_ren[1] && mwen && (mwaddr == rd_raddr2) && (mwaddr != 0);
`ifdef YSYX_23060201_GPR_WB_BYPASS_EN
    e_haz = (rd_ren[0] && mbusy[rd_raddr1] && !b1) || (rd_ren[1] && mbusy[rd_raddr2] && !b2);
    chk("byp_hit", byp_hit, {b2, b1});
    if (b1) chk("byp_data1", byp_data1, mwdata);
    if (b2) chk("byp_data2", byp_data2, mwdata);
`else
    e_haz = (rd_ren[0] && mbusy[rd_raddr1]) || (rd_ren[1] && mbusy[rd_raddr2]);
`endif
    chk("exu_ready", exu_ready, ge);
    chk("lsu_ready", lsu_ready, gl);
    chk("iss_ready", iss_ready, e_iss);
    chk("hazard", hazard, e_haz);
    acc    = ge || gl;
    a_rd   = gl ? lsu_rd : exu_rd;
    a_data = gl ? lsu_data : exu_data;
    @(posedge clk);
    if (mwen) mbusy[mwaddr] = 1'b0;
    if (iss_valid && e_iss && iss_rd != 0) mbusy[iss_rd] = 1'b1;
    if (acc) mlast_lsu = gl;
    if (acc && a_rd != 0) begin
      mwen = 1'b1; mwaddr = a_rd; mwdata = a_data;
    end else begin
      mwen = 1'b0;
    end
    #1;
    chk("gpr_wen", gpr_wen, mwen);
    chk("gpr_waddr", gpr_waddr, mwaddr);
    chk("gpr_wdata", gpr_wdata, mwdata);
    @(negedge clk);
  endtask

  initial begin
    int exr [4];
    int lsr [4];
    int wexp [4];
    int cands [$];
    int pick;
    exr = '{10, 12, 12, 12};
    lsr = '{11, 11, 13, 13};
    wexp = '{10, 11, 12, 13};

    // Reset state
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    rd_ren = 2'b11; rd_raddr1 = 1; rd_raddr2 = 2;
    #2;
    chk("rst_gpr_wen", gpr_wen, 1'b0);
    chk("rst_gpr_waddr", gpr_waddr, 5'd0);
    chk("rst_gpr_wdata", gpr_wdata, 32'd0);
    chk("rst_hazard", hazard, 1'b0);
    chk("rst_iss_ready", iss_ready, 1'b1);
    for (int r = 1; r < 32; r++) begin
      iss_rd = r[4:0];
      #1;
      chk("rst_busy_zero", iss_ready, 1'b1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    cycle();

    // Tie alternation from reset: EXU, LSU, EXU, LSU
    for (int i = 0; i < 4; i++) begin
      iss_valid = 1; iss_rd = 5'(10 + i);
      cycle();
    end
    iss_valid = 0;
    for (int i = 0; i < 4; i++) begin
      exu_valid = 1; exu_rd = 5'(exr[i]); exu_data = 32'h1000 + i;
      lsu_valid = 1; lsu_rd = 5'(lsr[i]); lsu_data = 32'h2000 + i;
      #1;
      chk("alt_exu_ready", exu_ready, (i % 2 == 0));
      cycle();
      chk("alt_waddr", gpr_waddr, 5'(wexp[i]));
      chk("alt_wen", gpr_wen, 1'b1);
    end
    idle_inputs();
    cycle();

    // Issue rd5, write it back, observe hazard and WAW stall until the commit edge
    iss_valid = 1; iss_rd = 5;
    cycle();
    iss_valid = 0;
    rd_ren = 2'b01; rd_raddr1 = 5;
    exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF;
    #1;
    chk("rd5_hazard_before_wb", hazard, 1'b1);
    cycle();
    chk("rd5_wen", gpr_wen, 1'b1);
    chk("rd5_waddr", gpr_waddr, 5'd5);
    chk("rd5_wdata", gpr_wdata, 32'hDEADBEEF);
    exu_valid = 0;
    iss_valid = 1; iss_rd = 5;
    #1;
    chk("rd5_iss_blocked", iss_ready, 1'b0);
`ifdef YSYX_23060201_GPR_WB_BYPASS_EN
    chk("rd5_bypass_no_hazard", hazard, 1'b0);
    chk("rd5_bypass_data", byp_data1, 32'hDEADBEEF);
`else
    chk("rd5_hazard_commit_cycle", hazard, 1'b1);
`endif
    cycle();
    #1;
    chk("rd5_iss_free", iss_ready, 1'b1);
    chk("rd5_hazard_clear", hazard, 1'b0);
    cycle();
    idle_inputs();

    // LSU writeback to x0: accepted, nothing committed
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
    #1;
    chk("x0_lsu_ready", lsu_ready, 1'b1);
    cycle();
    chk("x0_no_wen", gpr_wen, 1'b0);
    idle_inputs();
    cycle();

    // Reset with a write staged in the commit stage drops it
    iss_valid = 1; iss_rd = 20;
    cycle();
    iss_valid = 0;
    exu_valid = 1; exu_rd = 20; exu_data = 32'hCAFE0020;
    cycle();
    idle_inputs();
    rst_n = 1'b0;
    rd_ren = 2'b01; rd_raddr1 = 20; iss_rd = 5;
    #1;
    model_reset();
    chk("midrst_wen", gpr_wen, 1'b0);
    chk("midrst_hazard", hazard, 1'b0);
    chk("midrst_iss_ready", iss_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    cycle();

    // Randomized traffic; writebacks only target registers still awaiting one
    for (int n = 0; n < 400; n++) begin
      iss_valid = 1'($urandom);
      iss_rd    = 5'($urandom);
      rd_ren    = 2'($urandom);
      rd_raddr1 = 5'($urandom);
      rd_raddr2 = 5'($urandom);
      cands.delete();
      for (int r = 1; r < 32; r++)
        if (mbusy[r] && !(mwen && mwaddr == r)) cands.push_back(r);
      exu_valid = 0; lsu_valid = 0;
      exu_rd = 0; lsu_rd = 0;
      exu_data = $urandom; lsu_data = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        exu_valid = 1; exu_rd = 0;
      end else if (cands.size() > 0 && $urandom_range(0, 3) != 0) begin
        pick = $urandom_range(0, cands.size() - 1);
        exu_valid = 1; exu_rd = 5'(cands[pick]);
        cands.delete(pick);
      end
      if ($urandom_range(0, 7) == 0) begin
        lsu_valid = 1; lsu_rd = 0;
      end else if (cands.size() > 0 && $urandom_range(0, 3) != 0) begin
        pick = $urandom_range(0, cands.size() - 1);
        lsu_valid = 1; lsu_rd = 5'(cands[pick]);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
